lzrw1_decompressor_top: RTL and testbench

Streaming LZRW1-style decompressor. It consumes one 16-bit compressed item per handshake, each tagged with one control bit, and emits decompressed bytes one per clock. A circular history buffer of HISTORY_SIZE bytes holds recently output bytes, so copy items can reference them. It sits between the compressed-item source (control-word unpacker) and the byte sink.

---
 rtl/lzrw1_pkg.sv | 22 ++
 rtl/lzrw1_history_buf.sv | 33 +++
 rtl/lzrw1_decompressor_top.sv | 118 +++++++++++
 tb/tb_lzrw1_decompressor_top.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lzrw1_pkg.sv
// Shared constants and types for the LZRW1 streaming decompressor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lzrw1_pkg;

    // Control bit carried alongside each 16-bit compressed item
    localparam logic CTRL_LITERAL = 1'b0;
    localparam logic CTRL_COPY    = 1'b1;

    // Copy item layout: data[15:4] = back-offset, data[3:0] = length - LEN_BIAS
    localparam int LEN_BIAS = 3;
    localparam int OFFSET_W = 12;
    localparam int LEN_W    = 4;

    // IDLE: waiting for an item. COPY: emitting bytes; the cycle with
    // remaining == 0 after the last byte is the "done" slot that drops busy.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } state_e;

endpackage

// File: rtl/lzrw1_history_buf.sv
// Circular history of recently emitted bytes; one sync write port, one comb read port.
// Latency: write lands on the clock edge, read is combinational (same cycle).
// Backpressure: none; always accepts a write when wr_en is high.
// Ports: clock/reset (async active-low clear of every entry), wr_en/wr_addr/wr_dat,
//        rd_addr/rd_dat.
module lzrw1_history_buf #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_dat
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/lzrw1_decompressor_top.sv
// Streaming LZRW1 decompressor: literal/copy items in, one decompressed byte per clock out.
// Latency: byte 0 registered on the accepting edge; an item of length L holds busy for L cycles.
// Backpressure: decompressor_busy high while expanding; data_in_valid is ignored while busy.
// Ports: clock, reset (async active-low), data_in/control_word_in/data_in_valid (item in),
//        decompressed_byte/out_valid (byte out), decompressor_busy.
module lzrw1_decompressor_top
    import lzrw1_pkg::*;
#(
    parameter int HISTORY_SIZE = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        control_word_in,
    input  logic        data_in_valid,
    output logic [7:0]  decompressed_byte,
    output logic        out_valid,
    output logic        decompressor_busy
);

    localparam int AW    = $clog2(HISTORY_SIZE);
    localparam int REM_W = LEN_W + 1;

    state_e            state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [AW-1:0]     src_q, src_d;
    logic [AW-1:0]     wp_q, wp_d;
    logic [7:0]        byte_q, byte_d;
    logic              out_valid_q, out_valid_d;

    logic [AW-1:0]     rd_addr;
    logic [7:0]        rd_dat;
    logic [AW-1:0]     copy_src0;

    // Subtract at full offset width then truncate: power-of-two depth makes
    // this the offset taken modulo HISTORY_SIZE.
    assign copy_src0 = AW'(OFFSET_W'(wp_q) - data_in[15:LEN_W]);

    lzrw1_history_buf #(
        .DEPTH (HISTORY_SIZE),
        .AW    (AW)
    ) u_hist (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (out_valid_d),
        .wr_addr (wp_q),
        .wr_dat  (byte_d),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        src_d       = src_q;
        wp_d        = wp_q;
        byte_d      = byte_q;
        out_valid_d = 1'b0;
        rd_addr     = src_q;

        case (state_q)
            ST_IDLE: begin
                // Byte 0 of a copy reads straight from the incoming item
                rd_addr = copy_src0;
                if (data_in_valid) begin
                    state_d     = ST_COPY;
                    out_valid_d = 1'b1;
                    wp_d        = wp_q + AW'(1);
                    if (control_word_in == CTRL_COPY) begin
                        byte_d = rd_dat;
                        rem_d  = REM_W'(data_in[LEN_W-1:0]) + REM_W'(LEN_BIAS - 1);
                        src_d  = copy_src0 + AW'(1);
                    end else begin
                        byte_d = data_in[7:0];
                        rem_d  = '0;
                    end
                end
            end
            ST_COPY: begin
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    // Writes from earlier bytes of this copy are already in the
                    // buffer, so overlapping copies replicate naturally.
                    out_valid_d = 1'b1;
                    byte_d      = rd_dat;
                    src_d       = src_q + AW'(1);
                    wp_d        = wp_q + AW'(1);
                    rem_d       = rem_q - REM_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            src_q       <= '0;
            wp_q        <= '0;
            byte_q      <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            src_q       <= src_d;
            wp_q        <= wp_d;
            byte_q      <= byte_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign decompressed_byte = byte_q;
    assign out_valid         = out_valid_q;
    assign decompressor_busy = (state_q == ST_COPY);

endmodule

// File: tb/tb_lzrw1_decompressor_top.sv
// Self-checking bench for lzrw1_decompressor_top against a byte-level history model.
// Latency: n/a (testbench).
// Backpressure: items are only offered once decompressor_busy is low.
module tb_lzrw1_decompressor_top;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic        control_word_in = 1'b0;
    logic        data_in_valid = 1'b0;
    logic [7:0]  decompressed_byte;
    logic        out_valid;
    logic        decompressor_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain array history and write index
    logic [7:0] hist [256];
    int         wp;
    logic [7:0] exp_q [$];

    lzrw1_decompressor_top #(.HISTORY_SIZE(256)) dut (
        .clock             (clock),
        .reset             (reset),
        .data_in           (data_in),
        .control_word_in   (control_word_in),
        .data_in_valid     (data_in_valid),
        .decompressed_byte (decompressed_byte),
        .out_valid         (out_valid),
        .decompressor_busy (decompressor_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) hist[i] = 8'h00;
        wp = 0;
    endtask

    // Expected byte sequence of one item, updating the model history
    task automatic model_item(input logic ctrl, input logic [15:0] d);
        int off;
        int len;
        logic [7:0] b;
        exp_q.delete();
        if (ctrl == 1'b0) begin
            hist[wp] = d[7:0];
            exp_q.push_back(d[7:0]);
            wp = (wp + 1) % 256;
        end else begin
            off = int'(d[15:4]) % 256;
            len = int'(d[3:0]) + 3;
            for (int n = 0; n < len; n++) begin
                b = hist[(wp - off + 256) % 256];
                hist[wp] = b;
                exp_q.push_back(b);
                wp = (wp + 1) % 256;
            end
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while (decompressor_busy !== 1'b0 && c < 100) begin
            @(negedge clock);
            c++;
        end
        if (c >= 100) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Offer one item, then check every byte, the busy/out_valid window length
    // and the held output. With inject set, a literal 'Z' is held valid for the
    // whole busy window and must never be taken.
    task automatic send_item(input logic ctrl, input logic [15:0] d, input bit inject,
                             input string tag);
        int n;
        int cyc;
        wait_idle();
        control_word_in = ctrl;
        data_in         = d;
        data_in_valid   = 1'b1;
        model_item(ctrl, d);
        @(negedge clock);
        if (inject) begin
            control_word_in = 1'b0;
            data_in         = 16'h005A;
        end else begin
            data_in_valid = 1'b0;
        end
        n   = 0;
        cyc = 0;
        while (decompressor_busy === 1'b1 && cyc < 40) begin
            check({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
            if (n < exp_q.size()) check({tag, "_byte"}, {24'd0, decompressed_byte}, {24'd0, exp_q[n]});
            n++;
            cyc++;
            @(negedge clock);
        end
        data_in_valid = 1'b0;
        check({tag, "_len"}, n, exp_q.size());
        check({tag, "_ov_end"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_hold"}, {24'd0, decompressed_byte}, {24'd0, exp_q[exp_q.size()-1]});
        if (inject) begin
            @(negedge clock);
            check({tag, "_no_z"}, {31'd0, out_valid}, 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        data_in_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_busy", {31'd0, decompressor_busy}, 32'd0);
        check("rst_ov",   {31'd0, out_valid}, 32'd0);
        check("rst_byte", {24'd0, decompressed_byte}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Literals then a copy of them
        send_item(1'b0, 16'h0041, 1'b0, "lit_a");
        send_item(1'b0, 16'h0042, 1'b0, "lit_b");
        send_item(1'b0, 16'h0043, 1'b0, "lit_c");
        send_item(1'b1, 16'h0030, 1'b0, "copy_abc");
        check("copy_abc_last", {24'd0, decompressed_byte}, 32'h43);

        // Overlapping copy replicates a single byte
        send_item(1'b0, 16'h0058, 1'b0, "lit_x");
        send_item(1'b1, 16'h0012, 1'b0, "overlap");
        check("overlap_last", {24'd0, decompressed_byte}, 32'h58);

        // Input offered while busy must be ignored
        send_item(1'b1, 16'h0035, 1'b1, "inject");

        // Wrap-around from a clean history
        do_reset();
        for (int i = 0; i < 300; i++) send_item(1'b0, 16'(i % 256), 1'b0, "lit300");
        send_item(1'b1, 16'h100F, 1'b0, "wrap");
        check("wrap_last", {24'd0, decompressed_byte}, 32'd61);

        // Reset in the middle of an L=10 copy
        wait_idle();
        control_word_in = 1'b1;
        data_in         = 16'h0017;
        data_in_valid   = 1'b1;
        @(negedge clock);
        data_in_valid = 1'b0;
        check("midrst_b0_ov", {31'd0, out_valid}, 32'd1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst_ov",   {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, decompressor_busy}, 32'd0);
        check("midrst_byte", {24'd0, decompressed_byte}, 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("postrst_idle", {31'd0, out_valid}, 32'd0);
        send_item(1'b1, 16'h0010, 1'b0, "postrst");
        check("postrst_last", {24'd0, decompressed_byte}, 32'd0);

        // Randomized mix of literals and copies, some with busy-time injection
        for (int i = 0; i < 200; i++) begin
            send_item(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 7) == 0), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
